// File: rtl/alu_seq.sv
// Clocked ALU with valid/ready handshakes, a persistent carry flag for ADC/SBC chains,
// and iterative (one step per cycle) shift and shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int unsigned CW = SHW + 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_ADC = 4'h8;
    localparam logic [3:0] OP_SBC = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_shl_q, is_shl_d;
    logic             is_mul_q, is_mul_d;
    logic [WIDTH-1:0] result_d;
    logic             carry_d, overflow_d, zero_d, negative_d, out_valid_d;

    logic             accept_c;
    logic             sub_c, cin_c, multi_c;
    logic [WIDTH-1:0] bop_c;
    logic [WIDTH:0]   sum_c;
    logic [SHW-1:0]   k_c;
    logic [WIDTH-1:0] q_res_c;
    logic             q_carry_c, q_ovf_c;
    logic [PW-1:0]    acc_step_c;
    logic [WIDTH-1:0] work_step_c;
    logic             shout_c;

    // Held low through the reset cycle so nothing is accepted while state is being cleared.
    assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept_c = in_valid && in_ready;
    assign k_c      = B[SHW-1:0];
    assign multi_c  = (op == OP_MUL) || (((op == OP_SHL) || (op == OP_SHR)) && (k_c != '0));

    // Shared adder for ADD/SUB/ADC/SBC.
    always_comb begin
        sub_c = (op == OP_SUB) || (op == OP_SBC);
        bop_c = sub_c ? ~B : B;
        case (op)
            OP_SUB:         cin_c = 1'b1;
            OP_ADC, OP_SBC: cin_c = carry;
            default:        cin_c = 1'b0;
        endcase
        sum_c = {1'b0, A} + {1'b0, bop_c} + (WIDTH+1)'(cin_c);
    end

    // Single-cycle results; reserved ops fall through to zero with all flags clear.
    always_comb begin
        q_res_c   = '0;
        q_carry_c = 1'b0;
        q_ovf_c   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                q_res_c   = sum_c[WIDTH-1:0];
                q_carry_c = sum_c[WIDTH];
                q_ovf_c   = (A[WIDTH-1] == bop_c[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:         q_res_c = A & B;
            OP_OR:          q_res_c = A | B;
            OP_XOR:         q_res_c = A ^ B;
            OP_NOT:         q_res_c = ~A;
            OP_SHL, OP_SHR: q_res_c = A;
            default:        ;
        endcase
    end

    // One iteration: shift-add for MUL (work holds the multiplier), one-bit shift otherwise.
    always_comb begin
        acc_step_c  = work_q[0] ? (acc_q + mcand_q) : acc_q;
        work_step_c = is_shl_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
        shout_c     = is_shl_q ? work_q[WIDTH-1] : work_q[0];
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        is_shl_d    = is_shl_q;
        is_mul_d    = is_mul_q;
        result_d    = result;
        carry_d     = carry;
        overflow_d  = overflow;
        zero_d      = zero;
        negative_d  = negative;

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                work_d  = work_step_c;
                mcand_d = mcand_q << 1;
                acc_d   = acc_step_c;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = S_DONE;
                    overflow_d = 1'b0;
                    if (is_mul_q) begin
                        result_d = acc_step_c[WIDTH-1:0];
                        carry_d  = |acc_step_c[PW-1:WIDTH];
                    end else begin
                        result_d = work_step_c;
                        carry_d  = shout_c;
                    end
                    zero_d     = (result_d == '0);
                    negative_d = result_d[WIDTH-1];
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new op may be accepted from IDLE or in the same cycle DONE is consumed.
        if (accept_c) begin
            is_shl_d = (op == OP_SHL);
            is_mul_d = (op == OP_MUL);
            mcand_d  = PW'(A);
            acc_d    = '0;
            work_d   = (op == OP_MUL) ? B : A;
            cnt_d    = (op == OP_MUL) ? CW'(WIDTH) : CW'(k_c);
            if (multi_c) begin
                state_d = S_BUSY;
            end else begin
                state_d    = S_DONE;
                result_d   = q_res_c;
                carry_d    = q_carry_c;
                overflow_d = q_ovf_c;
                zero_d     = (q_res_c == '0);
                negative_d = q_res_c[WIDTH-1];
            end
        end

        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            is_shl_q  <= 1'b0;
            is_mul_q  <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            is_shl_q  <= is_shl_d;
            is_mul_q  <= is_mul_d;
            result    <= result_d;
            carry     <= carry_d;
            overflow  <= overflow_d;
            zero      <= zero_d;
            negative  <= negative_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver predicts each accepted op with an arithmetic model,
// an independent monitor pops and compares on every output handshake.
module tb_alu_seq;

    localparam int unsigned W = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, carry, negative, overflow;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
    );

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           lat;
        int           c0;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mode     = 0;
    bit   mc       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the op rules, carry kept as model state.
    task automatic push_expect(input logic [3:0] o, input int unsigned a, input int unsigned b, input int c0);
        exp_t        e;
        int unsigned s, r, bb, k;
        bit          c, v;
        r = 0; c = 0; v = 0; bb = b; e.lat = 1; k = b % W;
        case (o)
            4'h0: s = a + b;
            4'h1: begin bb = ~b & MASK; s = a + bb + 1; end
            4'h8: s = a + b + mc;
            4'h9: begin bb = ~b & MASK; s = a + bb + mc; end
            default: s = 0;
        endcase
        case (o)
            4'h0, 4'h1, 4'h8, 4'h9: begin
                r = s & MASK;
                c = ((s >> W) & 1) != 0;
                v = (((a >> (W-1)) & 1) == ((bb >> (W-1)) & 1)) && (((r >> (W-1)) & 1) != ((a >> (W-1)) & 1));
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a & MASK;
            4'h6: begin
                if (k == 0) r = a;
                else begin s = a << k; r = s & MASK; c = ((s >> W) & 1) != 0; e.lat = 1 + k; end
            end
            4'h7: begin
                if (k == 0) r = a;
                else begin r = a >> k; c = ((a >> (k-1)) & 1) != 0; e.lat = 1 + k; end
            end
            4'hA: begin s = a * b; r = s & MASK; c = (s >> W) != 0; e.lat = 1 + W; end
            default: ;
        endcase
        mc    = c;
        e.res = W'(r);
        e.fl  = {(r == 0), c, ((r >> (W-1)) & 1) != 0, v};
        e.c0  = c0;
        sb.push_back(e);
    endtask

    task automatic drive_ready();
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit acc;
        int tries, c0;
        acc = 1'b0; tries = 0;
        while (!acc) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b1; op = o; A = av; B = bv;
            #1;
            acc = in_ready;
            c0  = cyc;
            @(posedge clk);
            if (acc) push_expect(o, av, bv, c0);
            else if (++tries > 200) begin
                check("accept_timeout", 32'(tries), 32'd0);
                break;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        mode = 0;
        while (sb.size() != 0 && n < 500) begin idle(1); n++; end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_flags"}, 32'({zero, carry, negative, overflow}), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Monitor: latency measured to first out_valid, compared on the handshake.
    initial begin
        bit   fresh;
        int   first;
        exp_t e;
        fresh = 1'b1; first = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                fresh = 1'b1;
            end else begin
                if (out_valid && fresh) begin first = cyc; fresh = 1'b0; end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("result", 32'(result), 32'(e.res));
                        check("flags_zcnv", 32'({zero, carry, negative, overflow}), 32'(e.fl));
                        check("latency", 32'(first - e.c0), 32'(e.lat));
                    end
                    fresh = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [W+3:0] snap;
        int           n;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = '0; out_ready = 1'b0;

        @(negedge clk);
        #1 check("in_ready_during_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

        mode = 0;
        issue(4'h0, 8'hFF, 8'h01);
        issue(4'h1, 8'h80, 8'h01);
        issue(4'h1, 8'h00, 8'h01);
        issue(4'h0, 8'hFF, 8'h01);
        issue(4'h8, 8'h12, 8'h00);
        issue(4'h6, 8'h81, 8'd3);
        issue(4'h7, 8'h81, 8'd1);
        issue(4'h6, 8'h5A, 8'd0);
        issue(4'hC, 8'h55, 8'h33);
        drain();

        // Backpressure on a finished MUL: outputs frozen, no new op accepted.
        mode = 2;
        issue(4'hA, 8'h10, 8'h11);
        n = 0;
        while (!out_valid && n < 50) begin idle(1); #1; n++; end
        check("mul_valid_seen", 32'(out_valid), 32'd1);
        snap = {result, zero, carry, negative, overflow};
        repeat (5) begin
            idle(1);
            #1;
            check("hold_outputs", 32'({result, zero, carry, negative, overflow}), 32'(snap));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        drain();

        // Reset three cycles into a MUL discards it and clears the carry left by the ADD.
        issue(4'h0, 8'hFF, 8'h01);
        drain();
        issue(4'hA, 8'h10, 8'h11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("mid_mul_reset");
        sb.delete();
        mc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        #1 check("no_valid_after_reset", 32'(out_valid), 32'd0);
        issue(4'h2, 8'hF0, 8'h3C);
        drain();

        // Randomized ops, including reserved codes, under random backpressure.
        mode = 1;
        repeat (300) begin
            issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        drain();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
